lsu: RTL

- Load/store unit for the multicycle core, directly downstream of the ALU.
- In the memory state it takes the effective address the ALU computes for loads and stores (rs1 + imm), plus rs2 and funct3. It runs one word-aligned bus transaction and returns sign/zero-extended load data for writeback.
- It replaces ad-hoc memory access in the top-level state machine with a handshake and alignment and timeout checks.

---
 rtl/core_pkg.sv | 20 ++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: RV32I load/store funct3 codes and the LSU state encoding.
package core_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned STRB_W = XLEN / 8;

   // RV32I load/store width and sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

endpackage : core_pkg

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   funct3/offset/is_load : access width, byte offset within the word, direction
//   store_val             : rs2 value, replicated onto the byte lanes as wdata
//   rdata                 : bus read word, from which ldata is extracted and extended
//   wstrb                 : byte enables for stores
//   bad                   : funct3 illegal for the direction, or address misaligned
module lsu_align
   import core_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [1:0]        offset,
   input  logic              is_load,
   input  logic [XLEN-1:0]   store_val,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   wdata,
   output logic [STRB_W-1:0] wstrb,
   output logic [XLEN-1:0]   ldata,
   output logic              bad
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Byte and halfword selected from the read word by the offset
   always_comb begin
      byte_v = rdata[7:0];
      case (offset)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   // Lane placement, extension and legality per funct3
   always_comb begin
      wdata = store_val;
      wstrb = 4'b1111;
      ldata = rdata;
      bad   = 1'b0;
      case (funct3)
         F3_B: begin
            wdata = {4{store_val[7:0]}};
            wstrb = 4'b0001 << offset;
            ldata = {{24{byte_v[7]}}, byte_v};
         end
         F3_H: begin
            wdata = {2{store_val[15:0]}};
            wstrb = 4'b0011 << offset;
            ldata = {{16{half_v[15]}}, half_v};
            bad   = offset[0];
         end
         F3_W: begin
            bad = |offset;
         end
         F3_BU: begin
            ldata = {24'h0, byte_v};
            bad   = !is_load;
         end
         F3_HU: begin
            ldata = {16'h0, half_v};
            bad   = !is_load || offset[0];
         end
         default: begin
            bad = 1'b1;
         end
      endcase
   end

endmodule : lsu_align

// File: rtl/lsu.sv
// Load/store unit: one word-aligned bus transaction per accepted request, with
// legality checks, a ready timeout and sign/zero-extended load data.
//   clk, rst_n            : clock, synchronous active-low reset
//   start/is_load/is_store/funct3/addr/store_val : request from the core
//   busy, done, err, load_data                   : status and result to the core
//   mem_req/we/addr/wdata/wstrb, mem_ready/rdata : memory bus
module lsu
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_load,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_val,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       load_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_MAX  = (TIMEOUT == 0) ? 1 : TIMEOUT;
   localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   lsu_state_t        state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic              is_ld_q, is_ld_d;
   logic              hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;

   logic [2:0]        a_f3;
   logic [1:0]        a_off;
   logic              a_ld;
   logic [31:0]       a_wdata;
   logic [3:0]        a_wstrb;
   logic [31:0]       a_ldata;
   logic              a_bad;

   // Lane logic sees the live request in IDLE and the latched access afterwards
   always_comb begin
      if (state_q == ST_IDLE) begin
         a_f3  = funct3;
         a_off = addr[1:0];
         a_ld  = is_load;
      end else begin
         a_f3  = f3_q;
         a_off = off_q;
         a_ld  = is_ld_q;
      end
   end

   lsu_align u_align (
      .funct3    (a_f3),
      .offset    (a_off),
      .is_load   (a_ld),
      .store_val (store_val),
      .rdata     (mem_rdata),
      .wdata     (a_wdata),
      .wstrb     (a_wstrb),
      .ldata     (a_ldata),
      .bad       (a_bad)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         is_ld_q     <= 1'b0;
         hold_q      <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         load_data_q <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         is_ld_q     <= is_ld_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         load_data_q <= load_data_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      f3_d        = f3_q;
      off_d       = off_q;
      is_ld_d     = is_ld_q;
      hold_d      = hold_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      err_d       = err_q;
      load_data_d = load_data_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               f3_d    = funct3;
               off_d   = addr[1:0];
               is_ld_d = is_load;
               err_d   = 1'b0;
               if ((is_load == is_store) || a_bad) begin
                  // Rejected without touching the bus; one extra RESP cycle
                  // keeps done at the same latency as a zero-wait access.
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  hold_d  = 1'b1;
               end else begin
                  state_d     = ST_REQ;
                  cnt_d       = '0;
                  mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  mem_we_d    = is_store;
                  mem_wdata_d = is_store ? a_wdata : 32'h0;
                  mem_wstrb_d = is_store ? a_wstrb : 4'h0;
               end
            end
         end
         ST_REQ: begin
            if (mem_ready) begin
               state_d = ST_RESP;
               done_d  = 1'b1;
               err_d   = 1'b0;
               if (is_ld_q) begin
                  load_data_d = a_ldata;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_LAST))) begin
               state_d     = ST_RESP;
               done_d      = 1'b1;
               err_d       = 1'b1;
               load_data_d = 32'h0;
            end else if (cnt_q != CNT_W'(CNT_MAX)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (hold_q) begin
               hold_d = 1'b0;
               done_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
         end
      endcase

      busy_d    = (state_d != ST_IDLE);
      mem_req_d = (state_d == ST_REQ);
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign load_data = load_data_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule : lsu
